// File: rtl/stripe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stripe_pkg
//  Description : Shared types and constants for the two-lane byte striper:
//                FSM state encoding, lane-mode codes and width defaults.
//  Revision    : 1.0 - initial release
// ============================================================================
package stripe_pkg;

    localparam int DW_DEFAULT = 8;
    localparam int CW_DEFAULT = 16;

    // Lane-mode codes, bit0 = lane 0 enabled, bit1 = lane 1 enabled
    localparam logic [1:0] MODE_OFF  = 2'b00;
    localparam logic [1:0] MODE_L0   = 2'b01;
    localparam logic [1:0] MODE_L1   = 2'b10;
    localparam logic [1:0] MODE_BOTH = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        L0   = 2'd1,
        L1   = 2'd2
    } state_t;

endpackage : stripe_pkg
`default_nettype wire

// File: rtl/stripe_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : stripe_ctrl_if
//  Description : Byte input and two-lane output bundle of the striper.
//                master = byte source / lane consumer, slave = striper.
//  Revision    : 1.0 - initial release
// ============================================================================
interface stripe_ctrl_if
    import stripe_pkg::*;
#(
    parameter int DW = DW_DEFAULT,
    parameter int CW = CW_DEFAULT
);
    logic [DW-1:0] data_in;
    logic          valid_in;
    logic [1:0]    lane_en;
    logic          flush;
    logic [DW-1:0] lane_0;
    logic [DW-1:0] lane_1;
    logic          valid_0;
    logic          valid_1;
    logic [CW-1:0] cnt_0;
    logic [CW-1:0] cnt_1;
    logic [7:0]    drop_cnt;
    logic          sel;

    modport master (
        output data_in, valid_in, lane_en, flush,
        input  lane_0, lane_1, valid_0, valid_1, cnt_0, cnt_1, drop_cnt, sel
    );

    modport slave (
        input  data_in, valid_in, lane_en, flush,
        output lane_0, lane_1, valid_0, valid_1, cnt_0, cnt_1, drop_cnt, sel
    );

endinterface : stripe_ctrl_if
`default_nettype wire

// File: rtl/lane_counter.sv
`default_nettype none
// ============================================================================
//  Module      : lane_counter
//  Description : CW-bit wrapping event counter with synchronous clear.
//  Revision    : 1.0 - initial release
// ============================================================================
module lane_counter
    import stripe_pkg::*;
#(
    parameter int CW = CW_DEFAULT
) (
    input  wire logic          clk_2f,
    input  wire logic          i_clr,
    input  wire logic          i_inc,
    output logic      [CW-1:0] o_cnt
);

    logic [CW-1:0] r_cnt;

    // Count one per inc pulse; rolls over silently at full scale
    always_ff @(posedge clk_2f) begin
        if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule : lane_counter
`default_nettype wire

// File: rtl/stripe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : stripe_ctrl
//  Description : Stripes an incoming byte stream across two output lanes.
//                The lane mode is latched only at pair boundaries (next
//                state L0) so a pair started on lane 0 always completes on
//                lane 1 before a new lane_en takes effect.
//  Revision    : 1.0 - initial release
// ============================================================================
module stripe_ctrl
    import stripe_pkg::*;
#(
    parameter int DW = DW_DEFAULT,
    parameter int CW = CW_DEFAULT
) (
    input  wire logic   clk_2f,
    input  wire logic   reset,
    stripe_ctrl_if.slave bus
);

    state_t        r_state;
    logic [1:0]    r_mode;
    logic [DW-1:0] r_lane_0;
    logic [DW-1:0] r_lane_1;
    logic          r_valid_0;
    logic          r_valid_1;
    logic [7:0]    r_drop_cnt;
    logic          r_sel;

    state_t        w_state_nxt;
    logic          w_disp_0;
    logic          w_disp_1;
    logic          w_drop;
    logic [CW-1:0] w_cnt_0;
    logic [CW-1:0] w_cnt_1;

    // Next-state and dispatch decode; idle cycles hold the state
    always_comb begin
        w_state_nxt = r_state;
        w_disp_0    = 1'b0;
        w_disp_1    = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            IDLE: w_state_nxt = L0;
            L0, L1: begin
                if (bus.valid_in) begin
                    case (r_mode)
                        MODE_BOTH: begin
                            if (r_state == L1) begin
                                w_disp_1    = 1'b1;
                                w_state_nxt = L0;
                            end else begin
                                w_disp_0    = 1'b1;
                                w_state_nxt = L1;
                            end
                        end
                        MODE_L0: begin
                            w_disp_0    = 1'b1;
                            w_state_nxt = L0;
                        end
                        MODE_L1: begin
                            w_disp_1    = 1'b1;
                            w_state_nxt = L0;
                        end
                        default: begin
                            w_drop      = 1'b1;
                            w_state_nxt = L0;
                        end
                    endcase
                end
                // The current byte still goes out per the old state
                if (bus.flush) begin
                    w_state_nxt = L0;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register, mode latch and registered lane outputs
    always_ff @(posedge clk_2f) begin
        if (reset) begin
            r_state    <= IDLE;
            r_mode     <= MODE_BOTH;
            r_lane_0   <= '0;
            r_lane_1   <= '0;
            r_valid_0  <= 1'b0;
            r_valid_1  <= 1'b0;
            r_drop_cnt <= '0;
            r_sel      <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_sel     <= (w_state_nxt == L1);
            r_valid_0 <= w_disp_0;
            r_valid_1 <= w_disp_1;
            if (w_state_nxt == L0) begin
                r_mode <= bus.lane_en;
            end
            if (w_disp_0) begin
                r_lane_0 <= bus.data_in;
            end
            if (w_disp_1) begin
                r_lane_1 <= bus.data_in;
            end
            if (w_drop && (r_drop_cnt != 8'hFF)) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

    lane_counter #(.CW(CW)) u_cnt_0 (
        .clk_2f (clk_2f),
        .i_clr  (reset),
        .i_inc  (w_disp_0),
        .o_cnt  (w_cnt_0)
    );

    lane_counter #(.CW(CW)) u_cnt_1 (
        .clk_2f (clk_2f),
        .i_clr  (reset),
        .i_inc  (w_disp_1),
        .o_cnt  (w_cnt_1)
    );

    assign bus.lane_0   = r_lane_0;
    assign bus.lane_1   = r_lane_1;
    assign bus.valid_0  = r_valid_0;
    assign bus.valid_1  = r_valid_1;
    assign bus.cnt_0    = w_cnt_0;
    assign bus.cnt_1    = w_cnt_1;
    assign bus.drop_cnt = r_drop_cnt;
    assign bus.sel      = r_sel;

endmodule : stripe_ctrl
`default_nettype wire

// File: tb/tb_stripe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stripe_ctrl
//  Description : Scoreboard bench for stripe_ctrl (DW = 8, CW = 4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stripe_ctrl;

    localparam int TB_DW = 8;
    localparam int TB_CW = 4;

    typedef struct {
        bit         lane;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic clk_2f = 1'b0;
    logic reset  = 1'b1;
    int   cyc    = 0;
    int   n_vec  = 0;
    int   n_err  = 0;
    exp_t q[$];

    stripe_ctrl_if #(.DW(TB_DW), .CW(TB_CW)) bus ();

    stripe_ctrl #(.DW(TB_DW), .CW(TB_CW)) dut (
        .clk_2f (clk_2f),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 clk_2f = ~clk_2f;

    always @(posedge clk_2f) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic f);
        @(negedge clk_2f);
        bus.valid_in = v;
        bus.data_in  = d;
        bus.flush    = f;
    endtask

    // Byte d is expected on lane ln right after the coming edge
    task automatic send(input logic [7:0] d, input bit ln, input logic f);
        drive(1'b1, d, f);
        q.push_back('{ln, d, cyc + 1});
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 8'h00, 1'b0);
    endtask

    // One reset edge, check the cleared outputs, then release (IDLE edge next)
    task automatic do_reset(input logic [1:0] en);
        @(negedge clk_2f);
        bus.lane_en  = en;
        bus.valid_in = 1'b0;
        bus.flush    = 1'b0;
        reset        = 1'b1;
        @(negedge clk_2f);
        check("rst_lane_0",   32'(bus.lane_0),   32'h0);
        check("rst_lane_1",   32'(bus.lane_1),   32'h0);
        check("rst_valid",    32'({bus.valid_1, bus.valid_0}), 32'h0);
        check("rst_cnt_0",    32'(bus.cnt_0),    32'h0);
        check("rst_cnt_1",    32'(bus.cnt_1),    32'h0);
        check("rst_drop_cnt", 32'(bus.drop_cnt), 32'h0);
        check("rst_sel",      32'(bus.sel),      32'h0);
        reset = 1'b0;
    endtask

    // Monitor: pops the scoreboard whenever a lane presents a byte
    initial begin
        exp_t       e;
        bit         a_lane;
        logic [7:0] a_data;
        forever begin
            @(posedge clk_2f);
            #1;
            if (bus.valid_0 === 1'b1 && bus.valid_1 === 1'b1) begin
                n_vec++;
                n_err++;
                $display("FAIL both_valid: got valid_0=1 valid_1=1, expected at most one high");
            end else if (bus.valid_0 === 1'b1 || bus.valid_1 === 1'b1) begin
                n_vec++;
                a_lane = bus.valid_1;
                a_data = a_lane ? bus.lane_1 : bus.lane_0;
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_byte: got lane %0d data %0h, expected no output", a_lane, a_data);
                end else begin
                    e = q.pop_front();
                    if (a_lane !== e.lane || a_data !== e.data || cyc != e.cyc) begin
                        n_err++;
                        $display("FAIL lane_byte: got lane %0d data %0h cyc %0d, expected lane %0d data %0h cyc %0d",
                                 a_lane, a_data, cyc, e.lane, e.data, e.cyc);
                    end
                end
            end else if (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                n_vec++;
                n_err++;
                $display("FAIL missing_byte: got no valid at cyc %0d, expected lane %0d data %0h",
                         cyc, e.lane, e.data);
            end
        end
    end

    initial begin
        bus.data_in  = '0;
        bus.valid_in = 1'b0;
        bus.lane_en  = 2'b11;
        bus.flush    = 1'b0;
        repeat (2) @(posedge clk_2f);

        // Mode 11 alternation on back-to-back bytes
        do_reset(2'b11);
        send(8'hFF, 1'b0, 1'b0);
        send(8'hEE, 1'b1, 1'b0);
        send(8'hDD, 1'b0, 1'b0);
        send(8'hCC, 1'b1, 1'b0);
        idle(1);
        check("alt_cnt_0", 32'(bus.cnt_0), 32'd2);
        check("alt_cnt_1", 32'(bus.cnt_1), 32'd2);
        check("alt_sel",   32'(bus.sel),   32'd0);

        // Idle gap does not advance the pairing; lane 0 holds its byte
        do_reset(2'b11);
        send(8'h03, 1'b0, 1'b0);
        idle(1);
        check("gap_sel_a", 32'(bus.sel), 32'd1);
        idle(1);
        check("gap_sel_b", 32'(bus.sel), 32'd1);
        send(8'h04, 1'b1, 1'b0);
        idle(1);
        check("gap_sel_end",   32'(bus.sel),    32'd0);
        check("gap_lane0_hold", 32'(bus.lane_0), 32'h03);

        // lane_en change inside a pair waits for the lane 1 byte
        do_reset(2'b11);
        send(8'hAA, 1'b0, 1'b0);
        bus.lane_en = 2'b01;
        send(8'h99, 1'b1, 1'b0);
        send(8'h12, 1'b0, 1'b0);
        send(8'h13, 1'b0, 1'b0);
        idle(1);
        check("mode_sw_sel",   32'(bus.sel),   32'd0);
        check("mode_sw_cnt_0", 32'(bus.cnt_0), 32'd3);

        // Mode 00: drops saturate; the valid_in seen in IDLE is not a drop
        do_reset(2'b00);
        bus.valid_in = 1'b1;
        bus.data_in  = 8'h55;
        for (int i = 0; i < 10; i++) drive(1'b1, 8'(i), 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        check("drop_10", 32'(bus.drop_cnt), 32'd10);
        for (int i = 0; i < 290; i++) drive(1'b1, 8'(i), 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        check("drop_sat", 32'(bus.drop_cnt), 32'd255);
        check("drop_cnt_0", 32'(bus.cnt_0), 32'd0);

        // Flush with byte, flush alone, then mid-stream reset
        do_reset(2'b11);
        send(8'h07, 1'b0, 1'b1);
        send(8'h08, 1'b0, 1'b0);
        send(8'h09, 1'b1, 1'b0);
        send(8'h0B, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b1);
        drive(1'b0, 8'h00, 1'b0);
        check("flush_sel",   32'(bus.sel),   32'd0);
        check("flush_cnt_0", 32'(bus.cnt_0), 32'd3);
        check("flush_cnt_1", 32'(bus.cnt_1), 32'd1);
        send(8'h0C, 1'b0, 1'b0);
        idle(1);
        check("pre_rst_sel", 32'(bus.sel), 32'd1);
        do_reset(2'b11);
        send(8'h0E, 1'b0, 1'b0);
        idle(1);
        check("post_rst_cnt_0", 32'(bus.cnt_0), 32'd1);

        // Counter wrap at CW = 4 in mode 01
        do_reset(2'b01);
        for (int i = 0; i < 15; i++) send(8'h20 + 8'(i), 1'b0, 1'b0);
        idle(1);
        check("wrap_cnt_15", 32'(bus.cnt_0), 32'd15);
        send(8'h40, 1'b0, 1'b0);
        send(8'h41, 1'b0, 1'b0);
        idle(1);
        check("wrap_cnt_0", 32'(bus.cnt_0), 32'd1);
        check("wrap_cnt_1", 32'(bus.cnt_1), 32'd0);

        idle(3);
        check("queue_drained", 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_stripe_ctrl
`default_nettype wire

// File: doc/stripe_ctrl.md
STRIPE_CTRL -- requirements
Module: stripe_ctrl

Interface
REQ-001 SHALL have parameter DW, default 8, meaning byte/lane data width.
REQ-002 SHALL have parameter CW, default 16, meaning per-lane byte counter width.
REQ-003 SHALL have port clk_2f  input  1  striping clock; the only clock in the block.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port data_in  input  DW  incoming byte.
REQ-006 SHALL have port valid_in  input  1  data_in carries a byte this cycle.
REQ-007 SHALL have port lane_en  input  2  lane enable configuration; bit0 = lane 0, bit1 = lane 1.
REQ-008 SHALL have port flush  input  1  forces the selector back to lane 0.
REQ-009 SHALL have ports lane_0 and lane_1  output  DW each  registered lane bytes.
REQ-010 SHALL have ports valid_0 and valid_1  output  1 each  lane byte valid.
REQ-011 SHALL have ports cnt_0 and cnt_1  output  CW each  bytes dispatched per lane.
REQ-012 SHALL have port drop_cnt  output  8  bytes dropped while no lane is enabled.
REQ-013 SHALL have port sel  output  1  lane that receives the next dispatched byte.

Function
REQ-014 SHALL implement the FSM states IDLE, L0 and L1; reset enters IDLE; sel = 1 only in L1.
REQ-015 IDLE SHALL go to L0 on the cycle after reset deasserts, then load the active mode from lane_en.
REQ-016 The active mode SHALL be re-sampled from lane_en only when the next state is L0 (pair boundary); lane_en changes in L1 SHALL take effect after the lane 1 byte.
REQ-017 Mode 11: every accepted byte SHALL go to the lane given by the state, then L0->L1->L0 alternates; idle cycles (valid_in = 0) SHALL NOT advance the state.
REQ-018 Mode 01: every byte SHALL go to lane 0 and the state SHALL stay L0; mode 10: every byte SHALL go to lane 1 and the state SHALL stay L0.
REQ-019 Mode 00: bytes SHALL NOT be dispatched; drop_cnt SHALL increment per valid_in and saturate at 255.
REQ-020 Latency SHALL be 1 cycle: a byte accepted at edge N appears on lane_x with valid_x = 1 after edge N, for exactly one cycle.
REQ-021 At most one of valid_0 and valid_1 SHALL be high in any cycle.
REQ-022 A lane with valid_x = 0 SHALL hold its previous lane_x value.
REQ-023 cnt_x SHALL increment on each dispatch to lane x and wrap from 2^CW-1 to 0 without a flag.
REQ-024 flush with valid_in in the same cycle SHALL dispatch that byte per the current state, then force next state L0 and re-sample lane_en.
REQ-025 flush without valid_in SHALL force next state L0; the counters SHALL be unaffected.
REQ-026 valid_in while in IDLE SHALL be ignored and SHALL NOT be counted as a drop.

Reset
REQ-027 With reset high at a clk_2f edge, the following SHALL be 0 after that edge: lane_0, lane_1, valid_0, valid_1, cnt_0, cnt_1, drop_cnt, sel; the active mode SHALL be 11 and the state IDLE.
REQ-028 Reset asserted mid-stream SHALL discard any in-flight pairing; the first byte after release SHALL go to lane 0.

Structure
REQ-029 Package stripe_pkg SHALL hold the FSM state encoding, the lane mode constants (MODE_OFF, MODE_L0, MODE_L1, MODE_BOTH) and the DW/CW defaults.
REQ-030 Sub-module lane_counter (CW-bit wrapping counter with inc and synchronous clear) SHALL be instantiated twice for cnt_0 and cnt_1.

Verification
REQ-031 Mode 11, bytes FF, EE, DD, CC on consecutive cycles -> lane_0 FF then DD, lane_1 EE then CC, each 1 cycle after input; cnt_0 = cnt_1 = 2.
REQ-032 Mode 11, 03, gap of 2 cycles, 04 -> 03 on lane 0, 04 on lane 1; sel stays 1 during the gap.
REQ-033 Mode 11, byte AA accepted (state L1), lane_en changed to 01, then 99, 12 -> 99 on lane 1, 12 on lane 0.
REQ-034 Mode 00, 300 valid bytes -> no valid_x pulses; drop_cnt = 255.
REQ-035 Mode 11, flush together with byte 07, then 08 -> 07 on lane 0, 08 on lane 0; reset asserted mid-stream -> all outputs 0 and the next byte goes to lane 0.
REQ-036 cnt_0 preloaded near wrap (CW = 4), 17 bytes in mode 01 -> cnt_0 = 1.
